// File: rtl/rst_sequencer.sv
// Reset sequencer: a fixed-length power-on reset pulse, then round-robin arbitrated
// soft-reset pulses, each followed by a cooldown window.
module rst_sequencer #(
  parameter int PULSE_LEN   = 3,
  parameter int HOLDOFF_LEN = 4,
  parameter int NUM_REQ     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rst_out,
  output logic               busy,
  output logic               done,
  output logic [7:0]         rst_count
);

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    HOLDOFF = 2'd1,
    IDLE    = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [7:0]         pulse_cnt_r, pulse_cnt_s;
  logic [7:0]         hold_cnt_r, hold_cnt_s;
  logic [7:0]         rst_count_r, rst_count_s;
  logic [2:0]         ptr_r, ptr_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_s;
  logic               rst_out_r, rst_out_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;

  logic [7:0]         req_pad_s;
  logic [3:0]         idx_s;
  logic [3:0]         nxt_ptr_s;
  logic [2:0]         pick_idx_s;
  logic               pick_vld_s;

  // Round-robin pick: scan from the priority pointer, wrapping at NUM_REQ.
  always_comb begin
    req_pad_s  = 8'(req);
    idx_s      = 4'd0;
    pick_idx_s = 3'd0;
    pick_vld_s = 1'b0;
    nxt_ptr_s  = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = {1'b0, ptr_r} + 4'(i);
      if (idx_s >= 4'(NUM_REQ)) begin
        idx_s = idx_s - 4'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!pick_vld_s && req_pad_s[idx_s[2:0]]) begin
        pick_vld_s = 1'b1;
        pick_idx_s = idx_s[2:0];
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
    nxt_ptr_s = {1'b0, pick_idx_s} + 4'd1;
    if (nxt_ptr_s >= 4'(NUM_REQ)) begin
      nxt_ptr_s = 4'd0;
    end else begin
      nxt_ptr_s = nxt_ptr_s;
    end
  end

  // Next-state and next-output logic; outputs are registered one edge later.
  always_comb begin
    state_s     = state_r;
    pulse_cnt_s = pulse_cnt_r;
    hold_cnt_s  = hold_cnt_r;
    rst_count_s = rst_count_r;
    ptr_s       = ptr_r;
    gnt_s       = '0;
    rst_out_s   = rst_out_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    case (state_r)
      ASSERT: begin
        rst_out_s = 1'b1;
        busy_s    = 1'b1;
        if (pulse_cnt_r == 8'(PULSE_LEN - 1)) begin
          state_s     = HOLDOFF;
          pulse_cnt_s = 8'd0;
          hold_cnt_s  = 8'd0;
          rst_out_s   = 1'b0;
          done_s      = 1'b1;
          rst_count_s = (rst_count_r == 8'd255) ? 8'd255 : rst_count_r + 8'd1;
        end else begin
          pulse_cnt_s = pulse_cnt_r + 8'd1;
        end
      end
      HOLDOFF: begin
        rst_out_s = 1'b0;
        busy_s    = 1'b1;
        if (hold_cnt_r == 8'(HOLDOFF_LEN - 1)) begin
          state_s    = IDLE;
          hold_cnt_s = 8'd0;
          busy_s     = 1'b0;
        end else begin
          hold_cnt_s = hold_cnt_r + 8'd1;
        end
      end
      IDLE: begin
        rst_out_s = 1'b0;
        busy_s    = 1'b0;
        if (pick_vld_s) begin
          state_s     = ASSERT;
          pulse_cnt_s = 8'd0;
          gnt_s       = NUM_REQ'(8'd1 << pick_idx_s);
          ptr_s       = nxt_ptr_s[2:0];
          rst_out_s   = 1'b1;
          busy_s      = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s     = ASSERT;
        pulse_cnt_s = 8'd0;
        hold_cnt_s  = 8'd0;
        rst_out_s   = 1'b1;
        busy_s      = 1'b1;
      end
    endcase
  end

  // State and output registers; reset forces the start of a fresh power-on pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ASSERT;
      pulse_cnt_r <= 8'd0;
      hold_cnt_r  <= 8'd0;
      rst_count_r <= 8'd0;
      ptr_r       <= 3'd0;
      gnt_r       <= '0;
      rst_out_r   <= 1'b1;
      busy_r      <= 1'b1;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      pulse_cnt_r <= pulse_cnt_s;
      hold_cnt_r  <= hold_cnt_s;
      rst_count_r <= rst_count_s;
      ptr_r       <= ptr_s;
      gnt_r       <= gnt_s;
      rst_out_r   <= rst_out_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign gnt       = gnt_r;
  assign rst_out   = rst_out_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign rst_count = rst_count_r;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed self-checking bench for rst_sequencer with default parameters
// (PULSE_LEN=3, HOLDOFF_LEN=4, NUM_REQ=2).
module tb_rst_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       rst_out;
  logic       busy;
  logic       done;
  logic [7:0] rst_count;

  int n_pass  = 0;
  int n_total = 0;

  rst_sequencer #(
    .PULSE_LEN  (3),
    .HOLDOFF_LEN(4),
    .NUM_REQ    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .rst_out  (rst_out),
    .busy     (busy),
    .done     (done),
    .rst_count(rst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // After a grant edge (or reset release): 3 high edges, done, then 4 holdoff cycles.
  task automatic pulse_then_idle(input string tag, input logic [7:0] exp_cnt);
    tick(1); chk({tag, "_hi1"}, 32'(rst_out), 32'd1);
    tick(1); chk({tag, "_hi2"}, 32'(rst_out), 32'd1);
    tick(1);
    chk({tag, "_fall"}, 32'(rst_out), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cnt"}, 32'(rst_count), 32'(exp_cnt));
    tick(3);
    chk({tag, "_hbusy"}, 32'(busy), 32'd1);
    chk({tag, "_dlow"}, 32'(done), 32'd0);
    tick(1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_ngnt"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req = 2'b00;

    // Reset state
    tick(2);
    chk("rst_out", 32'(rst_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(rst_count), 32'd0);

    // Power-on pulse
    rst = 1'b0;
    pulse_then_idle("por", 8'd1);
    for (int k = 0; k < 50; k++) begin
      tick(1);
      chk("por_quiet", {29'd0, rst_out, done, busy}, 32'd0);
    end
    chk("por_cnt_hold", 32'(rst_count), 32'd1);

    // Single requester held: grant, pulse, regrant on first IDLE cycle
    req = 2'b10;
    tick(1);
    chk("r1_gnt", 32'(gnt), 32'b10);
    chk("r1_rst", 32'(rst_out), 32'd1);
    pulse_then_idle("r1", 8'd2);
    tick(1);
    chk("r1_regnt", 32'(gnt), 32'b10);
    req = 2'b00;
    pulse_then_idle("r1b", 8'd3);

    // Both requesters: round-robin 01, 10, 01
    req = 2'b11;
    tick(1);
    chk("rr_g0", 32'(gnt), 32'b01);
    tick(1);
    chk("rr_g0_1cyc", 32'(gnt), 32'd0);
    tick(6);
    chk("rr_idle0", 32'(busy), 32'd0);
    tick(1);
    chk("rr_g1", 32'(gnt), 32'b10);
    tick(7);
    tick(1);
    chk("rr_g2", 32'(gnt), 32'b01);
    req = 2'b00;
    pulse_then_idle("rr", 8'd6);

    // Request that appears in ASSERT and vanishes in HOLDOFF is never granted
    req = 2'b10;
    tick(1);
    chk("drop_gnt", 32'(gnt), 32'b10);
    req = 2'b00;
    tick(1);
    req = 2'b01;
    tick(2);
    chk("drop_done", 32'(done), 32'd1);
    chk("drop_cnt", 32'(rst_count), 32'd7);
    tick(1);
    req = 2'b00;
    tick(3);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("drop_quiet", {28'd0, gnt, rst_out, busy}, 32'd0);
    end
    chk("drop_cnt2", 32'(rst_count), 32'd7);

    // Reset on the 2nd edge of a granted pulse
    req = 2'b01;
    tick(1);
    chk("ab_gnt", 32'(gnt), 32'b01);
    req = 2'b00;
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("ab_cnt", 32'(rst_count), 32'd0);
    chk("ab_rst", 32'(rst_out), 32'd1);
    chk("ab_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    pulse_then_idle("ab", 8'd1);

    // Reset coincident with a grant clears it; pointer returns to 0
    req = 2'b11;
    rst = 1'b1;
    tick(1);
    chk("gclr_gnt", 32'(gnt), 32'd0);
    chk("gclr_cnt", 32'(rst_count), 32'd0);
    rst = 1'b0;
    req = 2'b00;
    pulse_then_idle("gclr", 8'd1);
    req = 2'b11;
    tick(1);
    chk("ptr0_gnt", 32'(gnt), 32'b01);
    req = 2'b00;
    pulse_then_idle("ptr0", 8'd2);

    // 300 back-to-back pulses: counter saturates at 255
    req = 2'b01;
    for (int n = 0; n < 300; n++) begin
      int exp_cnt;
      exp_cnt = (n + 3 > 255) ? 255 : n + 3;
      tick(1);
      chk("sat_gnt", 32'(gnt), 32'b01);
      tick(2);
      chk("sat_hi", 32'(rst_out), 32'd1);
      tick(1);
      chk("sat_fall", {30'd0, rst_out, done}, 32'b01);
      chk("sat_cnt", 32'(rst_count), 32'(exp_cnt));
      tick(4);
    end
    req = 2'b00;
    chk("sat_final", 32'(rst_count), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
